// File: rtl/turn_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : turn_input_conditioner                                      |
// | Description : Synchronizes and debounces the left/right turn switches,   |
// |               producing clean levels, edge pulses and a 2-bit turn mode. |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module turn_input_conditioner #(
    parameter int DEBOUNCE_BITS = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       l_raw,
    input  logic       r_raw,
    output logic       l_clean,
    output logic       r_clean,
    output logic       l_rise,
    output logic       r_rise,
    output logic       l_fall,
    output logic       r_fall,
    output logic [1:0] mode,
    output logic       mode_chg
);

    localparam logic [DEBOUNCE_BITS-1:0] c_cnt_max = '1;

    logic [1:0] w_raw;
    logic [1:0] w_clean;
    logic [1:0] w_rise;
    logic [1:0] w_fall;

    // bit 0 = left channel, bit 1 = right channel
    assign w_raw = {r_raw, l_raw};

    for (genvar i = 0; i < 2; i++) begin : g_chan
        logic                     r_s1;
        logic                     r_s2;
        logic                     r_clean;
        logic                     r_rise;
        logic                     r_fall;
        logic [DEBOUNCE_BITS-1:0] r_cnt;
        logic                     w_commit;

        // Commit only after the counter saturated on an uninterrupted disagreement.
        assign w_commit = (r_s2 != r_clean) && (r_cnt == c_cnt_max);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_clean <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1   <= w_raw[i];
                r_s2   <= r_s1;
                r_rise <= w_commit &&  r_s2;
                r_fall <= w_commit && !r_s2;
                if (r_s2 == r_clean) begin
                    r_cnt <= '0;
                end else if (w_commit) begin
                    r_clean <= r_s2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_clean[i] = r_clean;
        assign w_rise[i]  = r_rise;
        assign w_fall[i]  = r_fall;
    end

    logic [1:0] r_mode;
    logic       r_mode_chg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= 2'b00;
            r_mode_chg <= 1'b0;
        end else begin
            r_mode     <= w_clean;
            r_mode_chg <= (w_clean != r_mode);
        end
    end

    assign l_clean  = w_clean[0];
    assign r_clean  = w_clean[1];
    assign l_rise   = w_rise[0];
    assign r_rise   = w_rise[1];
    assign l_fall   = w_fall[0];
    assign r_fall   = w_fall[1];
    assign mode     = r_mode;
    assign mode_chg = r_mode_chg;

endmodule
`default_nettype wire

// File: tb/tb_turn_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_turn_input_conditioner                                   |
// | Description : Scoreboard bench; a history-window model predicts outputs. |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_turn_input_conditioner;

    localparam int DEBOUNCE_BITS = 2;
    localparam int c_win         = 1 << DEBOUNCE_BITS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       l_raw = 1'b0;
    logic       r_raw = 1'b0;
    logic       l_clean, r_clean, l_rise, r_rise, l_fall, r_fall, mode_chg;
    logic [1:0] mode;

    turn_input_conditioner #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) dut (
        .clk      (clk),
        .rst      (rst),
        .l_raw    (l_raw),
        .r_raw    (r_raw),
        .l_clean  (l_clean),
        .r_clean  (r_clean),
        .l_rise   (l_rise),
        .r_rise   (r_rise),
        .l_fall   (l_fall),
        .r_fall   (r_fall),
        .mode     (mode),
        .mode_chg (mode_chg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Expected {l_clean,r_clean,l_rise,r_rise,l_fall,r_fall,mode,mode_chg}
    logic [8:0] exp_q[$];

    // Raw samples per channel, oldest first; reset refills with zeros.
    bit   hist_l[$];
    bit   hist_r[$];
    bit   m_clean_l, m_clean_r, m_rise_l, m_rise_r, m_fall_l, m_fall_r, m_chg;
    bit [1:0] m_mode;

    // The clean level flips once the synchronized input (raw delayed by
    // two edges) has disagreed with it for c_win consecutive edges.
    function automatic bit flips(input bit h[$], input bit clean);
        if (h.size() < c_win + 2) return 1'b0;
        for (int j = 0; j < c_win; j++)
            if (h[h.size() - 3 - j] == clean) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit       f_l, f_r;
        bit [1:0] nm;
        if (rst) begin
            hist_l.delete();
            hist_r.delete();
            for (int j = 0; j < c_win + 2; j++) begin
                hist_l.push_back(1'b0);
                hist_r.push_back(1'b0);
            end
            {m_clean_l, m_clean_r, m_rise_l, m_rise_r, m_fall_l, m_fall_r} = '0;
            m_mode = 2'b00;
            m_chg  = 1'b0;
        end else begin
            hist_l.push_back(l_raw);
            hist_r.push_back(r_raw);
            if (hist_l.size() > 64) void'(hist_l.pop_front());
            if (hist_r.size() > 64) void'(hist_r.pop_front());
            nm     = {m_clean_r, m_clean_l};
            m_chg  = (nm != m_mode);
            m_mode = nm;
            f_l = flips(hist_l, m_clean_l);
            f_r = flips(hist_r, m_clean_r);
            m_rise_l = f_l && !m_clean_l;
            m_fall_l = f_l &&  m_clean_l;
            m_rise_r = f_r && !m_clean_r;
            m_fall_r = f_r &&  m_clean_r;
            if (f_l) m_clean_l = !m_clean_l;
            if (f_r) m_clean_r = !m_clean_r;
        end
        exp_q.push_back({m_clean_l, m_clean_r, m_rise_l, m_rise_r,
                         m_fall_l, m_fall_r, m_mode, m_chg});
    end

    always @(negedge clk) begin
        logic [8:0] got, exp;
        cyc++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {l_clean, r_clean, l_rise, r_rise, l_fall, r_fall, mode, mode_chg};
            n_cmp++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL outputs@cycle%0d: got %b required %b (lc rc lr rr lf rf mode chg)",
                         cyc, got, exp);
            end
            n_cmp++;
            if ((l_rise && l_fall) || (r_rise && r_fall)) begin
                n_bad++;
                $display("FAIL rise_fall_exclusive@cycle%0d: got l=%b%b r=%b%b required not both",
                         cyc, l_rise, l_fall, r_rise, r_fall);
            end
        end
    end

    task automatic drive(input bit rs, input bit l, input bit r, input int n);
        rst   = rs;
        l_raw = l;
        r_raw = r;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        bit burst;
        // Reset held with both switches on, then release
        drive(1, 1, 1, 3);
        drive(0, 1, 1, 10);
        drive(0, 0, 0, 10);
        // Clean left press and release
        drive(0, 1, 0, 10);
        drive(0, 0, 0, 10);
        // Right glitch, then bounce 1,0,1,1,1,1
        drive(0, 0, 1, 3);
        drive(0, 0, 0, 8);
        drive(0, 0, 1, 1);
        drive(0, 0, 0, 1);
        drive(0, 0, 1, 4);
        drive(0, 0, 0, 10);
        // Simultaneous press and release
        drive(0, 1, 1, 10);
        drive(0, 0, 0, 10);
        // Reset mid-count
        drive(0, 1, 0, 3);
        drive(1, 1, 0, 1);
        drive(0, 1, 0, 10);
        drive(0, 0, 0, 10);
        // Randomized: alternating bouncy and stable stretches, rare resets
        burst = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            bit l, r, rs;
            if ($urandom_range(0, 39) == 0) burst = !burst;
            l  = l_raw;
            r  = r_raw;
            if ($urandom_range(0, burst ? 1 : 11) == 0) l = !l;
            if ($urandom_range(0, burst ? 1 : 11) == 0) r = !r;
            rs = ($urandom_range(0, 199) == 0);
            drive(rs, l, r, 1);
        end
        drive(0, 0, 0, 12);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
